// File: rtl/router_pkg.sv
// Shared types for the 1x3 router control FSM: state encoding and address constants.
package router_pkg;

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  localparam logic [1:0] ADDR_INVALID  = 2'd3;
  localparam int         NUM_PORTS_DEF = 3;

endpackage

// File: rtl/router_fsm_if.sv
// Control bundle between the router FSM (master) and the register block / FIFOs / source (slave).
interface router_fsm_if;

  logic       pktvalid;
  logic [1:0] din;
  logic       fifofull;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       lowpktvalid;

  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;
  logic       drop_pkt;

  modport master (
    input  pktvalid, din, fifofull, fifo_empty, soft_reset, parity_done, lowpktvalid,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, drop_pkt
  );

  modport slave (
    output pktvalid, din, fifofull, fifo_empty, soft_reset, parity_done, lowpktvalid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, drop_pkt
  );

endinterface

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address and sequences header/payload/parity loads into the target FIFO.
// Latency: Moore strobes are registered and follow the state one edge after the deciding inputs.
// Backpressure: busy stalls the source outside DA/LD; ROUTER_FSM_TIMEOUT_EN adds a WAIT_TILL_EMPTY abort with drop_pkt.
module router_fsm
  import router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF
`ifdef ROUTER_FSM_TIMEOUT_EN
  , parameter int WTE_TIMEOUT = 64
`endif
) (
  input  logic            clk,
  input  logic            rst,
  router_fsm_if.master    bus
);

  localparam logic [1:0] MAX_ADDR = 2'(NUM_PORTS - 1);

  state_t     state;
  state_t     nxt;
  logic [1:0] addr_q;
  logic [3:0] empty_x;
  logic [3:0] srst_x;
  logic       hdr_ok;

  // Pad to four entries so a 2-bit index never falls outside the vector.
  assign empty_x = {1'b0, bus.fifo_empty};
  assign srst_x  = {1'b0, bus.soft_reset};
  assign hdr_ok  = bus.pktvalid && (bus.din != ADDR_INVALID) && (bus.din <= MAX_ADDR);

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic [7:0] timer;
  logic       timeout_hit;
`endif

  always_comb begin
    nxt = state;
`ifdef ROUTER_FSM_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      DA:  if (hdr_ok) nxt = empty_x[bus.din] ? LFD : WTE;
      LFD: nxt = LD;
      LD: begin
        if (bus.fifofull)      nxt = FFS;
        else if (!bus.pktvalid) nxt = LP;
      end
      FFS: if (!bus.fifofull) nxt = LAF;
      LAF: begin
        if (bus.parity_done)      nxt = DA;
        else if (bus.lowpktvalid) nxt = LP;
        else                      nxt = LD;
      end
      LP:  nxt = CPE;
      CPE: nxt = bus.fifofull ? FFS : DA;
      WTE: begin
        if (empty_x[addr_q]) nxt = LFD;
`ifdef ROUTER_FSM_TIMEOUT_EN
        else if (timer == 8'(WTE_TIMEOUT - 1)) begin
          nxt         = DA;
          timeout_hit = 1'b1;
        end
`endif
      end
      default: nxt = DA;
    endcase
    // Soft reset of the addressed FIFO abandons the packet from any state.
    if (state != DA && srst_x[addr_q]) begin
      nxt = DA;
`ifdef ROUTER_FSM_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= DA;
      addr_q            <= 2'd0;
      bus.detect_add    <= 1'b1;
      bus.lfd_state     <= 1'b0;
      bus.ld_state      <= 1'b0;
      bus.laf_state     <= 1'b0;
      bus.full_state    <= 1'b0;
      bus.rst_int_reg   <= 1'b0;
      bus.write_enb_reg <= 1'b0;
      bus.busy          <= 1'b0;
`ifdef ROUTER_FSM_TIMEOUT_EN
      timer             <= 8'd0;
      bus.drop_pkt      <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == DA && hdr_ok) addr_q <= bus.din;
      bus.detect_add    <= (nxt == DA);
      bus.lfd_state     <= (nxt == LFD);
      bus.ld_state      <= (nxt == LD);
      bus.laf_state     <= (nxt == LAF);
      bus.full_state    <= (nxt == FFS);
      bus.rst_int_reg   <= (nxt == CPE);
      bus.write_enb_reg <= (nxt == LD) || (nxt == LAF) || (nxt == LP);
      bus.busy          <= !((nxt == DA) || (nxt == LD));
`ifdef ROUTER_FSM_TIMEOUT_EN
      // Held at zero outside WTE, so every entry starts a fresh count.
      timer        <= (state == WTE) ? timer + 8'd1 : 8'd0;
      bus.drop_pkt <= timeout_hit;
`endif
    end
  end

`ifndef ROUTER_FSM_TIMEOUT_EN
  assign bus.drop_pkt = 1'b0;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: packet-level stimulus pushes expected per-cycle states, a negedge monitor checks strobes.
module tb_router_fsm;
  import router_pkg::*;

  typedef struct packed {
    state_t st;
    logic   drop;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  router_fsm_if bus();

`ifdef ROUTER_FSM_TIMEOUT_EN
  router_fsm #(.WTE_TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  router_fsm dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Expected strobe vector from the Moore output table.
  function automatic logic [8:0] out_vec_of(state_t s, logic drop);
    return {s == DA, s == LFD, s == LD, s == LAF, s == FFS, s == CPE,
            (s == LD) || (s == LAF) || (s == LP), !((s == DA) || (s == LD)), drop};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
            bus.rst_int_reg, bus.write_enb_reg, bus.busy, bus.drop_pkt};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check($sformatf("cycle%0d_%s", cyc, mon_e.st.name()), dut_vec(), out_vec_of(mon_e.st, mon_e.drop));
    end
    cyc++;
  end

  function automatic logic       r1(); return 1'($urandom); endfunction
  function automatic logic [1:0] r2(); return 2'($urandom); endfunction
  function automatic logic [2:0] r3(); return 3'($urandom); endfunction
  function automatic logic [2:0] sr_ok(input logic [1:0] a);
    logic [2:0] m = r3();
    m[a] = 1'b0;
    return m;
  endfunction
  function automatic logic [2:0] fe_with(input logic [1:0] a, input logic v);
    logic [2:0] m = r3();
    m[a] = v;
    return m;
  endfunction

  // Apply one cycle of inputs; st is the state the FSM must be in during that cycle.
  task automatic step(input logic pv, input logic [1:0] d, input logic ff, input logic [2:0] fe,
                      input logic [2:0] sr, input logic pd, input logic lpv, input state_t st,
                      input logic drop = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    bus.pktvalid    = pv;
    bus.din         = d;
    bus.fifofull    = ff;
    bus.fifo_empty  = fe;
    bus.soft_reset  = sr;
    bus.parity_done = pd;
    bus.lowpktvalid = lpv;
    e.st   = st;
    e.drop = drop;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, r2(), r1(), r3(), r3(), r1(), r1(), DA);
  endtask

  // One packet: wait_c WTE cycles (0 = target already empty), payload LD bytes,
  // optional full stall before byte stall_at; laf_mode 0: resume, 1: lowpktvalid, 2: parity_done.
  task automatic run_packet(input logic [1:0] a, input int payload, input int wait_c,
                            input int stall_at, input int stall_len, input int laf_mode);
    step(1'b1, a, r1(), fe_with(a, wait_c == 0), r3(), r1(), r1(), DA);
    if (wait_c > 0) begin
      for (int w = 0; w < wait_c - 1; w++)
        step(r1(), r2(), r1(), fe_with(a, 1'b0), sr_ok(a), r1(), r1(), WTE);
      step(1'b1, r2(), r1(), fe_with(a, 1'b1), sr_ok(a), r1(), r1(), WTE);
    end
    step(1'b1, r2(), r1(), r3(), sr_ok(a), r1(), r1(), LFD);
    for (int i = 0; i < payload; i++) begin
      if (i == stall_at) begin
        step(1'b1, r2(), 1'b1, r3(), sr_ok(a), r1(), r1(), LD);
        for (int j = 1; j < stall_len; j++)
          step(1'b1, r2(), 1'b1, r3(), sr_ok(a), r1(), r1(), FFS);
        step(1'b1, r2(), 1'b0, r3(), sr_ok(a), r1(), r1(), FFS);
        if (laf_mode == 1) begin
          step(1'b0, r2(), r1(), r3(), sr_ok(a), 1'b0, 1'b1, LAF);
          step(1'b0, r2(), r1(), r3(), sr_ok(a), r1(), r1(), LP);
          step(1'b0, r2(), 1'b0, r3(), sr_ok(a), r1(), r1(), CPE);
          return;
        end
        if (laf_mode == 2) begin
          step(1'b0, r2(), r1(), r3(), sr_ok(a), 1'b1, r1(), LAF);
          return;
        end
        step(1'b1, r2(), r1(), r3(), sr_ok(a), 1'b0, 1'b0, LAF);
      end
      step(1'b1, r2(), 1'b0, r3(), sr_ok(a), r1(), r1(), LD);
    end
    step(1'b0, r2(), 1'b0, r3(), sr_ok(a), r1(), r1(), LD);
    step(1'b0, r2(), r1(), r3(), sr_ok(a), r1(), r1(), LP);
    step(1'b0, r2(), 1'b0, r3(), sr_ok(a), r1(), r1(), CPE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.pktvalid = 1'b0; bus.din = 2'd0; bus.fifofull = 1'b0; bus.fifo_empty = 3'b111;
    bus.soft_reset = 3'b000; bus.parity_done = 1'b0; bus.lowpktvalid = 1'b0;
    #12;
    check("reset_state", dut_vec(), out_vec_of(DA, 1'b0));
    @(negedge clk);
    rst = 1'b1;

    // Clean packet to addr 2: DA, LFD, LD x14, LP, CPE, DA
    run_packet(2'd2, 13, 0, -1, 0, 0);
    idle();
    // Target busy: 5 cycles non-empty then empty
    run_packet(2'd2, 3, 6, -1, 0, 0);
    idle();
    // Full stall on 3rd LD for 4 cycles, resume / lowpktvalid / parity_done
    run_packet(2'd1, 6, 0, 2, 4, 0);
    idle();
    run_packet(2'd1, 6, 0, 2, 4, 1);
    idle();
    run_packet(2'd0, 4, 0, 1, 2, 2);
    idle();

    // Soft reset: foreign bit ignored, own bit aborts
    step(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DA);
    step(1'b1, r2(), 1'b0, r3(), 3'b001, 1'b0, 1'b0, LFD);
    step(1'b1, r2(), 1'b0, r3(), 3'b001, 1'b0, 1'b0, LD);
    step(1'b1, r2(), 1'b0, r3(), 3'b101, 1'b0, 1'b0, LD);
    step(1'b1, r2(), 1'b0, r3(), 3'b010, 1'b0, 1'b0, LD);
    step(1'b0, r2(), 1'b0, r3(), 3'b000, 1'b0, 1'b0, DA);
    idle();

    // Invalid address header stays in DA
    step(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DA);
    step(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DA);
    idle();

    // CPE with fifofull goes to FFS
    step(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DA);
    step(1'b1, r2(), 1'b0, r3(), 3'b000, 1'b0, 1'b0, LFD);
    step(1'b0, r2(), 1'b0, r3(), 3'b000, 1'b0, 1'b0, LD);
    step(1'b0, r2(), 1'b0, r3(), 3'b000, 1'b0, 1'b0, LP);
    step(1'b0, r2(), 1'b1, r3(), 3'b000, 1'b0, 1'b0, CPE);
    step(1'b0, r2(), 1'b0, r3(), 3'b000, 1'b0, 1'b0, FFS);
    step(1'b0, r2(), 1'b0, r3(), 3'b000, 1'b1, 1'b0, LAF);
    idle();

`ifdef ROUTER_FSM_TIMEOUT_EN
    step(1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, DA);
    for (int w = 0; w < 8; w++)
      step(1'b0, r2(), r1(), fe_with(2'd0, 1'b0), sr_ok(2'd0), r1(), r1(), WTE);
    step(1'b0, r2(), r1(), r3(), r3(), r1(), r1(), DA, 1'b1);
    idle();
`else
    step(1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0, DA);
    for (int w = 0; w < 70; w++)
      step(r1(), r2(), r1(), fe_with(2'd0, 1'b0), sr_ok(2'd0), r1(), r1(), WTE);
    step(1'b1, r2(), r1(), fe_with(2'd0, 1'b1), sr_ok(2'd0), r1(), r1(), WTE);
    step(1'b0, r2(), r1(), r3(), sr_ok(2'd0), r1(), r1(), LFD);
    step(1'b0, r2(), 1'b0, r3(), sr_ok(2'd0), r1(), r1(), LD);
    step(1'b0, r2(), r1(), r3(), sr_ok(2'd0), r1(), r1(), LP);
    step(1'b0, r2(), 1'b0, r3(), sr_ok(2'd0), r1(), r1(), CPE);
    idle();
`endif

    // Randomized packets
    repeat (60) begin
      logic [1:0] a;
      int pl, wc, sa, sl, lm;
      a  = 2'($urandom_range(0, 2));
      pl = $urandom_range(1, 10);
      wc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
      sa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, pl - 1) : -1;
      sl = $urandom_range(1, 4);
      lm = $urandom_range(0, 2);
      run_packet(a, pl, wc, sa, sl, lm);
      idle();
    end

    // Asynchronous reset in the middle of LD
    step(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, DA);
    step(1'b1, r2(), 1'b0, r3(), 3'b000, 1'b0, 1'b0, LFD);
    step(1'b1, r2(), 1'b0, r3(), 3'b000, 1'b0, 1'b0, LD);
    step(1'b1, r2(), 1'b0, r3(), 3'b000, 1'b0, 1'b0, LD);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_mid_ld", dut_vec(), out_vec_of(DA, 1'b0));
    bus.pktvalid = 1'b0;
    @(posedge clk);
    #1;
    check("reset_held", dut_vec(), out_vec_of(DA, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    idle();
    run_packet(2'd1, 2, 0, -1, 0, 0);
    idle();

    repeat (3) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
